// File: rtl/frodo_out_framer_if.sv
// Bus bundle between main's output stream, the framer and the host.
// The slave modport is the framer's view; master is the environment's view.
interface frodo_out_framer_if;
   logic [1:0]  mode;
   logic        mode_isReady;
   logic        mode_canReceive;
   logic [63:0] in;
   logic        in_isReady;
   logic        in_canReceive;
   logic [63:0] out;
   logic [2:0]  out_field;
   logic        out_first;
   logic        out_last;
   logic        out_opLast;
   logic        out_isReady;
   logic        out_canReceive;
   logic        busy;
   logic        err;

   modport slave (
      input  mode, mode_isReady, in, in_isReady, out_canReceive,
      output mode_canReceive, in_canReceive, out, out_field, out_first,
             out_last, out_opLast, out_isReady, busy, err
   );

   modport master (
      output mode, mode_isReady, in, in_isReady, out_canReceive,
      input  mode_canReceive, in_canReceive, out, out_field, out_first,
             out_last, out_opLast, out_isReady, busy, err
   );
endinterface

// File: rtl/frodo_out_framer.sv
// FrodoKEM output framer: tags each 64-bit word from main with its field id,
// marks first/last word of every field and the last word of the operation,
// optionally byte-reverses the data. Single output register, full throughput.
module frodo_out_framer #(
   parameter int SWAP      = 1,
   parameter int W_SMALL_S = 4,
   parameter int W_MAT     = 2688,
   parameter int W_SEEDA   = 2,
   parameter int W_C2      = 16,
   parameter int W_SALT    = 8
) (
   input  logic                  clk,
   input  logic                  rst,
   frodo_out_framer_if.slave     bus
);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_RUN   = 2'd1,
      ST_DRAIN = 2'd2
   } state_t;

   // Field id of the idx-th field emitted for operation m.
   function automatic logic [2:0] field_id(input logic [1:0] m, input logic [2:0] idx);
      logic [2:0] id;
      id = 3'd0;
      case (m)
         2'd0: id = idx;                      // keygen ids run 0..4 in order
         2'd1: begin
            case (idx)
               3'd0:    id = 3'd5;
               3'd1:    id = 3'd6;
               3'd2:    id = 3'd7;
               default: id = 3'd0;            // ss closes encaps
            endcase
         end
         default: id = 3'd0;                  // decaps emits only ss
      endcase
      return id;
   endfunction

   // Number of 64-bit words in a field.
   function automatic logic [11:0] field_size(input logic [2:0] id);
      logic [11:0] sz;
      sz = 12'(W_SMALL_S);
      case (id)
         3'd0, 3'd4:       sz = 12'(W_SMALL_S);
         3'd1, 3'd3, 3'd5: sz = 12'(W_MAT);
         3'd2:             sz = 12'(W_SEEDA);
         3'd6:             sz = 12'(W_C2);
         3'd7:             sz = 12'(W_SALT);
         default:          sz = 12'(W_SMALL_S);
      endcase
      return sz;
   endfunction

   // Number of fields making up operation m.
   function automatic logic [2:0] field_count(input logic [1:0] m);
      logic [2:0] n;
      n = 3'd1;
      case (m)
         2'd0:    n = 3'd5;
         2'd1:    n = 3'd4;
         default: n = 3'd1;
      endcase
      return n;
   endfunction

   // Byte reversal: byte 0 <-> byte 7, 1 <-> 6, ...
   function automatic logic [63:0] byte_swap(input logic [63:0] d);
      logic [63:0] r;
      r = 64'd0;
      for (int i = 0; i < 8; i++) begin
         r[8*i +: 8] = d[8*(7-i) +: 8];
      end
      return r;
   endfunction

   state_t      state_r, state_s;
   logic [1:0]  mode_r, mode_s;
   logic [11:0] word_cnt_r, word_cnt_s;
   logic [2:0]  field_idx_r, field_idx_s;
   logic [63:0] out_r, out_s;
   logic [2:0]  field_r, field_s;
   logic        first_r, first_s;
   logic        last_r, last_s;
   logic        op_last_r, op_last_s;
   logic        valid_r, valid_s;
   logic        err_r, err_s;

   logic [2:0]  cur_id_s;
   logic [11:0] cur_size_s;
   logic        word_last_s;
   logic        field_last_s;
   logic        in_ready_s;
   logic        in_xfer_s;
   logic        out_xfer_s;
   logic        mode_xfer_s;
   logic [63:0] data_s;

   // Handshake qualifiers and tag lookup for the word currently expected.
   always_comb begin
      cur_id_s     = field_id(mode_r, field_idx_r);
      cur_size_s   = field_size(cur_id_s);
      word_last_s  = (word_cnt_r == (cur_size_s - 12'd1));
      field_last_s = (field_idx_r == (field_count(mode_r) - 3'd1));
      out_xfer_s   = valid_r & bus.out_canReceive;
      in_ready_s   = (state_r == ST_RUN) & (~valid_r | bus.out_canReceive);
      in_xfer_s    = in_ready_s & bus.in_isReady;
      mode_xfer_s  = (state_r == ST_IDLE) & bus.mode_isReady;
      if (SWAP != 0) begin
         data_s = byte_swap(bus.in);
      end else begin
         data_s = bus.in;
      end
   end

   // Next-state logic: operation sequencing, counters and output register load.
   always_comb begin
      state_s     = state_r;
      mode_s      = mode_r;
      word_cnt_s  = word_cnt_r;
      field_idx_s = field_idx_r;
      out_s       = out_r;
      field_s     = field_r;
      first_s     = first_r;
      last_s      = last_r;
      op_last_s   = op_last_r;
      err_s       = 1'b0;

      // A load wins over an unload so back-to-back words leave no bubble.
      if (in_xfer_s) begin
         valid_s = 1'b1;
      end else if (out_xfer_s) begin
         valid_s = 1'b0;
      end else begin
         valid_s = valid_r;
      end

      case (state_r)
         ST_IDLE: begin
            if (mode_xfer_s) begin
               if (bus.mode != 2'd3) begin
                  state_s     = ST_RUN;
                  mode_s      = bus.mode;
                  word_cnt_s  = 12'd0;
                  field_idx_s = 3'd0;
               end else begin
                  err_s = 1'b1;
               end
            end else begin
               state_s = ST_IDLE;
            end
         end
         ST_RUN: begin
            if (in_xfer_s) begin
               out_s     = data_s;
               field_s   = cur_id_s;
               first_s   = (word_cnt_r == 12'd0);
               last_s    = word_last_s;
               op_last_s = word_last_s & field_last_s;
               if (word_last_s) begin
                  word_cnt_s = 12'd0;
                  if (field_last_s) begin
                     state_s = ST_DRAIN;
                  end else begin
                     field_idx_s = field_idx_r + 3'd1;
                  end
               end else begin
                  word_cnt_s = word_cnt_r + 12'd1;
               end
            end else begin
               state_s = ST_RUN;
            end
         end
         ST_DRAIN: begin
            // The final word must leave before a new operation may start.
            if (out_xfer_s | ~valid_r) begin
               state_s     = ST_IDLE;
               field_idx_s = 3'd0;
            end else begin
               state_s = ST_DRAIN;
            end
         end
         default: begin
            state_s = ST_IDLE;
         end
      endcase
   end

   // State, counters and output register with synchronous reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r     <= ST_IDLE;
         mode_r      <= 2'd0;
         word_cnt_r  <= 12'd0;
         field_idx_r <= 3'd0;
         out_r       <= 64'd0;
         field_r     <= 3'd0;
         first_r     <= 1'b0;
         last_r      <= 1'b0;
         op_last_r   <= 1'b0;
         valid_r     <= 1'b0;
         err_r       <= 1'b0;
      end else begin
         state_r     <= state_s;
         mode_r      <= mode_s;
         word_cnt_r  <= word_cnt_s;
         field_idx_r <= field_idx_s;
         out_r       <= out_s;
         field_r     <= field_s;
         first_r     <= first_s;
         last_r      <= last_s;
         op_last_r   <= op_last_s;
         valid_r     <= valid_s;
         err_r       <= err_s;
      end
   end

   assign bus.out             = out_r;
   assign bus.out_field       = field_r;
   assign bus.out_first       = first_r;
   assign bus.out_last        = last_r;
   assign bus.out_opLast      = op_last_r;
   assign bus.out_isReady     = valid_r;
   assign bus.err             = err_r;
   assign bus.busy            = (state_r != ST_IDLE);
   assign bus.mode_canReceive = (state_r == ST_IDLE);
   assign bus.in_canReceive   = in_ready_s;

endmodule

// File: tb/tb_frodo_out_framer.sv
// Bench for frodo_out_framer: a table of operations is replayed against a
// field-table reference model; a SWAP=0 instance with a short matrix field
// covers the pass-through build.
module tb_frodo_out_framer;

   typedef struct packed {
      logic [63:0] data;
      logic [2:0]  field;
      logic        first;
      logic        last;
      logic        op_last;
   } word_t;

   typedef struct {
      int         sel;        // 0: SWAP=1 instance, 1: SWAP=0 short instance
      logic [1:0] mode;
      int         bp;         // 0 always ready, 1 toggling, 2 random
      bit         fixed;      // first word uses the documented pattern
      int         abort_at;   // >0: assert rst after this many input words
      int         exp_words;  // words expected out (-1 when aborted)
      bit         exp_err;
   } vec_t;

   localparam int W_MAT_SHORT = 3;

   logic clk = 1'b0;
   logic rst;
   logic [1:0]  mode_v;
   logic        mv;
   logic [63:0] din;
   logic        iv;
   logic        ocr;
   int          sel;

   int compared = 0;
   int mismatched = 0;

   frodo_out_framer_if if1 ();
   frodo_out_framer_if if0 ();

   frodo_out_framer #(.SWAP(1)) dut (.clk(clk), .rst(rst), .bus(if1.slave));
   frodo_out_framer #(.SWAP(0), .W_MAT(W_MAT_SHORT)) dut0 (.clk(clk), .rst(rst), .bus(if0.slave));

   assign if1.mode           = mode_v;
   assign if0.mode           = mode_v;
   assign if1.mode_isReady   = mv & (sel == 0);
   assign if0.mode_isReady   = mv & (sel == 1);
   assign if1.in             = din;
   assign if0.in             = din;
   assign if1.in_isReady     = iv;
   assign if0.in_isReady     = iv;
   assign if1.out_canReceive = ocr;
   assign if0.out_canReceive = ocr;

   wire [63:0] o_data  = sel ? if0.out             : if1.out;
   wire [2:0]  o_field = sel ? if0.out_field       : if1.out_field;
   wire        o_first = sel ? if0.out_first       : if1.out_first;
   wire        o_last  = sel ? if0.out_last        : if1.out_last;
   wire        o_opl   = sel ? if0.out_opLast      : if1.out_opLast;
   wire        o_valid = sel ? if0.out_isReady     : if1.out_isReady;
   wire        o_icr   = sel ? if0.in_canReceive   : if1.in_canReceive;
   wire        o_mcr   = sel ? if0.mode_canReceive : if1.mode_canReceive;
   wire        o_busy  = sel ? if0.busy            : if1.busy;
   wire        o_err   = sel ? if0.err             : if1.err;

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      compared++;
      if (act !== exp) begin
         mismatched++;
         $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   function automatic logic [63:0] bswap(input logic [63:0] d);
      logic [63:0] r;
      for (int i = 0; i < 8; i++) r[8*i +: 8] = d[8*(7-i) +: 8];
      return r;
   endfunction

   function automatic int size_of(input int id, input int s);
      case (id)
         0, 4:    return 4;
         1, 3, 5: return (s == 1) ? W_MAT_SHORT : 2688;
         2:       return 2;
         6:       return 16;
         7:       return 8;
         default: return 0;
      endcase
   endfunction

   task automatic run_op(input vec_t t);
      int    ids[$];
      word_t exp_q[$];
      logic [63:0] dq[$];
      int    n, in_ptr, out_ptr, cyc, budget;
      bit    in_x, o_x, hold_prev;
      word_t prev, cur;

      sel = t.sel;
      case (t.mode)
         2'd0:    ids = '{0, 1, 2, 3, 4};
         2'd1:    ids = '{5, 6, 7, 0};
         2'd2:    ids = '{0};
         default: ids = {};
      endcase
      for (int f = 0; f < ids.size(); f++) begin
         int sz = size_of(ids[f], t.sel);
         for (int w = 0; w < sz; w++) begin
            word_t e;
            logic [63:0] d;
            d = {$urandom, $urandom};
            if (t.fixed && dq.size() == 0) d = 64'h0011223344556677;
            dq.push_back(d);
            e.data    = (t.sel == 1) ? d : bswap(d);
            e.field   = 3'(ids[f]);
            e.first   = (w == 0);
            e.last    = (w == sz - 1);
            e.op_last = (w == sz - 1) && (f == ids.size() - 1);
            exp_q.push_back(e);
         end
      end
      n = exp_q.size();

      // mode handshake
      cyc = 0;
      @(negedge clk);
      while (!o_mcr && cyc < 20) begin
         @(negedge clk);
         cyc++;
      end
      check("mode_canReceive_before_op", {63'd0, o_mcr}, 64'd1);
      mode_v = t.mode;
      mv = 1'b1;
      @(negedge clk);
      mv = 1'b0;
      check("err_after_mode", {63'd0, o_err}, {63'd0, t.exp_err});
      if (t.exp_err) begin
         check("busy_after_illegal", {63'd0, o_busy}, 64'd0);
         check("mode_canReceive_after_illegal", {63'd0, o_mcr}, 64'd1);
         @(negedge clk);
         check("err_single_pulse", {63'd0, o_err}, 64'd0);
         check("busy_stays_low", {63'd0, o_busy}, 64'd0);
         return;
      end
      check("busy_after_mode", {63'd0, o_busy}, 64'd1);

      in_ptr = 0; out_ptr = 0; cyc = 0; hold_prev = 0;
      budget = n * 10 + 100;
      while (out_ptr < n && cyc < budget) begin
         if (t.abort_at > 0 && in_ptr >= t.abort_at) begin
            iv = 1'b0;
            rst = 1'b1;
            @(posedge clk);
            #1;
            check("reset_mid_op_out_isReady", {63'd0, o_valid}, 64'd0);
            check("reset_mid_op_busy", {63'd0, o_busy}, 64'd0);
            @(negedge clk);
            rst = 1'b0;
            return;
         end
         iv  = (in_ptr < n) && ($urandom_range(0, 3) != 0);
         din = (in_ptr < n) ? dq[in_ptr] : {$urandom, $urandom};
         case (t.bp)
            0:       ocr = 1'b1;
            1:       ocr = cyc[0];
            default: ocr = ($urandom_range(0, 2) != 0);
         endcase
         #1;
         cur = '{o_data, o_field, o_first, o_last, o_opl};
         if (hold_prev) check("held_word_stable", 64'(cur), 64'(prev));
         if (o_valid && !ocr) check("in_canReceive_low_while_held", {63'd0, o_icr}, 64'd0);
         in_x = iv & o_icr;
         o_x  = o_valid & ocr;
         if (o_x) begin
            check("word_data", cur.data, exp_q[out_ptr].data);
            check("word_tags", {59'd0, cur.field, cur.first, cur.last, cur.op_last},
                  {59'd0, exp_q[out_ptr].field, exp_q[out_ptr].first,
                   exp_q[out_ptr].last, exp_q[out_ptr].op_last});
            if (t.fixed && out_ptr == 0) check("decaps_w0_swapped", cur.data, 64'h7766554433221100);
         end
         hold_prev = o_valid & !ocr;
         prev = cur;
         @(posedge clk);
         if (in_x) in_ptr++;
         if (o_x) out_ptr++;
         @(negedge clk);
         cyc++;
      end
      iv = 1'b0;
      check("words_delivered", 64'(out_ptr), 64'(t.exp_words));
      check("busy_low_after_last_taken", {63'd0, o_busy}, 64'd0);
      check("mode_canReceive_after_op", {63'd0, o_mcr}, 64'd1);
      check("no_extra_word", {63'd0, o_valid}, 64'd0);
   endtask

   initial begin
      vec_t vecs[$];
      vecs.push_back('{0, 2'd2, 0, 1'b1, 0,   4,    1'b0});
      vecs.push_back('{0, 2'd0, 0, 1'b0, 0,   5386, 1'b0});
      vecs.push_back('{0, 2'd1, 1, 1'b0, 0,   2716, 1'b0});
      vecs.push_back('{0, 2'd3, 0, 1'b0, 0,   0,    1'b1});
      vecs.push_back('{0, 2'd0, 2, 1'b0, 100, -1,   1'b0});
      vecs.push_back('{0, 2'd2, 2, 1'b0, 0,   4,    1'b0});
      vecs.push_back('{1, 2'd1, 2, 1'b0, 0,   31,   1'b0});
      vecs.push_back('{0, 2'd2, 1, 1'b0, 0,   4,    1'b0});

      sel = 0; rst = 1'b1; mode_v = 2'd0; mv = 1'b0; din = 64'd0; iv = 1'b0; ocr = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      check("reset_out_isReady", {63'd0, o_valid}, 64'd0);
      check("reset_busy", {63'd0, o_busy}, 64'd0);
      check("reset_err", {63'd0, o_err}, 64'd0);
      check("reset_mode_canReceive", {63'd0, o_mcr}, 64'd1);
      check("reset_in_canReceive", {63'd0, o_icr}, 64'd0);
      check("reset_out", o_data, 64'd0);
      check("reset_tags", {59'd0, o_field, o_first, o_last, o_opl}, 64'd0);

      for (int v = 0; v < vecs.size(); v++) run_op(vecs[v]);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
